// File: rtl/stack_if.sv
// Sequencer-to-stack-engine bundle: push/pop handshakes, pointer load and status.
// The sequencer owns the requests (master); the stack engine answers (slave).
interface stack_if #(
  parameter int DATA_W = 32,
  parameter int PTR_W  = 5
);
  logic              push_req;
  logic [DATA_W-1:0] push_data;
  logic              pop_req;
  logic              sp_load;
  logic [PTR_W-1:0]  sp_set;
  logic              push_ack;
  logic              pop_ack;
  logic [DATA_W-1:0] pop_data;
  logic [PTR_W-1:0]  sp_out;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    output push_req, push_data, pop_req, sp_load, sp_set,
    input  push_ack, pop_ack, pop_data, sp_out, full, empty, err
  );

  modport slave (
    input  push_req, push_data, pop_req, sp_load, sp_set,
    output push_ack, pop_ack, pop_data, sp_out, full, empty, err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Upward-growing stack engine: serves push/pop/pointer-load requests from the
// sequencer, owns the private stack storage and the stack pointer.
//
// state  | meaning
// IDLE   | accepts one of sp_load > push_req > pop_req per cycle
// PUSH   | push_ack high (write already done on entry edge)
// POPRD  | reading mem[sp-1] into pop_data
// POPRSP | pop_ack high, pop_data valid
module stack_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 5
) (
  input  logic    clk,
  input  logic    rst,
  stack_if.slave  bus
);
  localparam int AW = PTR_W - 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, PUSH, POPRD, POPRSP} state_t;

  state_t            r_state;
  logic [PTR_W-1:0]  r_sp;
  logic [AW-1:0]     r_rd_addr;
  logic [DATA_W-1:0] r_pop_data;
  logic              r_push_ack;
  logic              r_pop_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_full;
  logic              w_empty;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_sp_inc;
  logic [PTR_W-1:0]  w_sp_dec;

  assign w_full   = (r_sp == DEPTH_P);
  assign w_empty  = (r_sp == '0);
  assign w_sp_inc = r_sp + PTR_W'(1);
  assign w_sp_dec = r_sp - PTR_W'(1);

  // Write happens on the accepting edge, so it must mirror the IDLE priority.
  assign w_wr_en = !rst && (r_state == IDLE) && !bus.sp_load && bus.push_req && !w_full;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_sp[AW-1:0]] <= bus.push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sp       <= '0;
      r_rd_addr  <= '0;
      r_pop_data <= '0;
      r_push_ack <= 1'b0;
      r_pop_ack  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_push_ack <= 1'b0;
      r_pop_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.sp_load) begin
            if (bus.sp_set <= DEPTH_P) r_sp <= bus.sp_set;
            else r_err <= 1'b1;
          end else if (bus.push_req) begin
            // Overflow still acks so the requester is never left hanging.
            r_push_ack <= 1'b1;
            r_state    <= PUSH;
            if (w_full) r_err <= 1'b1;
            else r_sp <= w_sp_inc;
          end else if (bus.pop_req) begin
            if (w_empty) begin
              r_err     <= 1'b1;
              r_pop_ack <= 1'b1;
              r_state   <= POPRSP;
            end else begin
              r_rd_addr <= w_sp_dec[AW-1:0];
              r_sp      <= w_sp_dec;
              r_state   <= POPRD;
            end
          end
        end
        PUSH: r_state <= IDLE;
        POPRD: begin
          r_pop_data <= r_mem[r_rd_addr];
          r_pop_ack  <= 1'b1;
          r_state    <= POPRSP;
        end
        POPRSP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.push_ack = r_push_ack;
  assign bus.pop_ack  = r_pop_ack;
  assign bus.pop_data = r_pop_data;
  assign bus.sp_out   = r_sp;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl: fixed-latency handshakes, boundaries, reset abort.
module tb_stack_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  stack_if #(.DATA_W(32), .PTR_W(5)) bus ();

  stack_ctrl #(.DATA_W(32), .DEPTH(16), .PTR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] d, input string tag);
    bus.push_req  = 1'b1;
    bus.push_data = d;
    step();
    check({tag, "_ack"}, 32'(bus.push_ack), 1);
    bus.push_req = 1'b0;
    step();
    check({tag, "_ack_end"}, 32'(bus.push_ack), 0);
  endtask

  task automatic do_pop(input logic [31:0] exp, input string tag);
    bus.pop_req = 1'b1;
    step();
    check({tag, "_ack_early"}, 32'(bus.pop_ack), 0);
    bus.pop_req = 1'b0;
    step();
    check({tag, "_ack"}, 32'(bus.pop_ack), 1);
    check({tag, "_data"}, bus.pop_data, exp);
    step();
    check({tag, "_ack_end"}, 32'(bus.pop_ack), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    bus.push_req  = 1'b0;
    bus.push_data = '0;
    bus.pop_req   = 1'b0;
    bus.sp_load   = 1'b0;
    bus.sp_set    = '0;
    do_reset();

    check("rst_sp", 32'(bus.sp_out), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_push_ack", 32'(bus.push_ack), 0);
    check("rst_pop_ack", 32'(bus.pop_ack), 0);
    check("rst_pop_data", bus.pop_data, 0);
    check("rst_err", 32'(bus.err), 0);

    do_push(32'd5791, "push5791");
    check("sp_after_1", 32'(bus.sp_out), 1);
    check("empty_after_1", 32'(bus.empty), 0);
    do_push(32'd7894, "push7894");
    check("sp_after_2", 32'(bus.sp_out), 2);

    do_pop(32'd7894, "pop7894");
    do_pop(32'd5791, "pop5791");
    check("sp_after_pops", 32'(bus.sp_out), 0);
    check("empty_after_pops", 32'(bus.empty), 1);
    check("err_after_pops", 32'(bus.err), 0);

    for (int i = 0; i < 16; i++) do_push(32'(i), "fill");
    check("full_16", 32'(bus.full), 1);
    check("sp_16", 32'(bus.sp_out), 16);
    check("err_before_ovf", 32'(bus.err), 0);
    do_push(32'hDEAD, "ovf");
    check("err_ovf", 32'(bus.err), 1);
    check("sp_ovf", 32'(bus.sp_out), 16);
    do_pop(32'd15, "pop_top");
    check("sp_15", 32'(bus.sp_out), 15);
    check("full_15", 32'(bus.full), 0);

    // Underflow: pop_data must keep the last popped word.
    do_reset();
    do_push(32'h33, "push33");
    do_pop(32'h33, "pop33");
    bus.pop_req = 1'b1;
    step();
    check("unf_ack", 32'(bus.pop_ack), 1);
    bus.pop_req = 1'b0;
    check("unf_err", 32'(bus.err), 1);
    check("unf_data", bus.pop_data, 32'h33);
    check("unf_sp", 32'(bus.sp_out), 0);
    step();
    check("unf_ack_end", 32'(bus.pop_ack), 0);

    // Simultaneous push and pop: push served first, pop on next IDLE cycle.
    do_push(32'h11, "push11");
    bus.push_req  = 1'b1;
    bus.pop_req   = 1'b1;
    bus.push_data = 32'hA5;
    step();
    check("sim_push_ack", 32'(bus.push_ack), 1);
    check("sim_pop_ack_n1", 32'(bus.pop_ack), 0);
    check("sim_sp_2", 32'(bus.sp_out), 2);
    bus.push_req = 1'b0;
    step();
    check("sim_sp_hold", 32'(bus.sp_out), 2);
    step();
    check("sim_pop_accept", 32'(bus.sp_out), 1);
    check("sim_pop_ack_n2", 32'(bus.pop_ack), 0);
    bus.pop_req = 1'b0;
    step();
    check("sim_pop_ack", 32'(bus.pop_ack), 1);
    check("sim_pop_data", bus.pop_data, 32'hA5);
    step();
    check("sim_sp_restored", 32'(bus.sp_out), 1);

    // Pointer load, including priority over a concurrent push.
    do_reset();
    bus.sp_load  = 1'b1;
    bus.sp_set   = 5'd3;
    bus.push_req = 1'b1;
    step();
    bus.sp_load  = 1'b0;
    bus.push_req = 1'b0;
    check("load3_sp", 32'(bus.sp_out), 3);
    check("load3_no_ack", 32'(bus.push_ack), 0);
    check("load3_err", 32'(bus.err), 0);
    bus.sp_load = 1'b1;
    bus.sp_set  = 5'd17;
    step();
    bus.sp_load = 1'b0;
    check("load17_err", 32'(bus.err), 1);
    check("load17_sp", 32'(bus.sp_out), 3);
    bus.sp_load = 1'b1;
    bus.sp_set  = 5'd16;
    step();
    bus.sp_load = 1'b0;
    check("load16_sp", 32'(bus.sp_out), 16);
    check("load16_full", 32'(bus.full), 1);

    // Reset while in POPRD aborts the pop.
    bus.pop_req = 1'b1;
    step();
    check("abort_sp_dec", 32'(bus.sp_out), 15);
    bus.pop_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_pop_ack", 32'(bus.pop_ack), 0);
    check("abort_sp", 32'(bus.sp_out), 0);
    check("abort_err", 32'(bus.err), 0);
    check("abort_empty", 32'(bus.empty), 1);
    step();
    check("abort_pop_ack_late", 32'(bus.pop_ack), 0);
    do_push(32'h77, "post_abort_push");
    do_pop(32'h77, "post_abort_pop");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
